// File: rtl/mem_write_checker_pkg.sv
// mem_write_checker_pkg: shared state encoding and width helpers for the
// memory-write checker and its expected-store table.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_e;

    // clog2 clamped to 1 so a single-entry table still has a 1-bit index
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Width of an entry index into a DEPTH-entry table
    function automatic int idx_width(input int depth);
        return clog2_min1(depth);
    endfunction

    // Width of a counter that must hold 0..DEPTH inclusive
    function automatic int cnt_width(input int depth);
        return clog2_min1(depth + 1);
    endfunction

    // Width of the idle timer, which counts 0..TIMEOUT-1
    function automatic int tmr_width(input int timeout);
        return clog2_min1(timeout);
    endfunction

    // Widths for the default parameter set
    localparam int DEF_IDX_W = idx_width(8);
    localparam int DEF_CNT_W = cnt_width(8);
    localparam int DEF_TMR_W = tmr_width(1024);

endpackage

// File: rtl/mem_write_checker_exp_table.sv
// exp_table: DEPTH x (ADDR_W + DATA_W) register file holding the expected
// stores. One synchronous write port, one combinational read port. Contents
// are not reset; the owner's entry count decides which entries are valid.
module exp_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [ADDR_W-1:0] wexp_addr_i,
    input  logic [DATA_W-1:0] wexp_data_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [ADDR_W-1:0] rexp_addr_o,
    output logic [DATA_W-1:0] rexp_data_o
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Write one expected entry when the loader hands it over
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            addr_mem[waddr_i] <= wexp_addr_i;
            data_mem[waddr_i] <= wexp_data_i;
        end
    end

    assign rexp_addr_o = addr_mem[ridx_i];
    assign rexp_data_o = data_mem[ridx_i];

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: watches a processor's data-memory write port and compares
// each store, in order, against a loaded table of expected (address, data)
// pairs. Produces a sticky registered PASS/FAIL verdict with first-mismatch
// capture. The inactivity timeout is built only when the macro
// MEM_WRITE_CHECKER_TIMEOUT_EN is defined; otherwise RUN waits indefinitely
// and timed_out_o is tied low.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    localparam int IDX_W  = idx_width(DEPTH),
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              start_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] WriteData_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timed_out_o,
    output logic [IDX_W-1:0]  fail_idx_o,
    output logic [ADDR_W-1:0] got_addr_o,
    output logic [DATA_W-1:0] got_data_o,
    output logic [CNT_W-1:0]  match_cnt_o
);

    chk_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [ADDR_W-1:0] got_addr_q, got_addr_d;
    logic [DATA_W-1:0] got_data_q, got_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              load_fire;
    logic [CNT_W-1:0]  count_nx;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              store_ok;
    logic              last_entry;

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    localparam int TMR_W = tmr_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              timed_out_q, timed_out_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    assign load_ready_o = (state_q == IDLE) && (count_q < CNT_W'(DEPTH));
    assign load_fire    = load_valid_i && load_ready_o;
    assign count_nx     = count_q + CNT_W'(load_fire);
    assign store_ok     = (ALUResult_i == exp_addr) && (WriteData_i == exp_data);
    assign last_entry   = (CNT_W'(idx_q) == count_q - CNT_W'(1));

    exp_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_exp_table (
        .clk_i       (clk_i),
        .we_i        (load_fire),
        .waddr_i     (count_q[IDX_W-1:0]),
        .wexp_addr_i (load_addr_i),
        .wexp_data_i (load_data_i),
        .ridx_i      (idx_q),
        .rexp_addr_o (exp_addr),
        .rexp_data_o (exp_data)
    );

    // Next-state: loading, arming, per-store compare, timeout and capture
    always_comb begin
        state_d     = state_q;
        count_d     = count_nx;
        idx_d       = idx_q;
        match_cnt_d = match_cnt_q;
        fail_idx_d  = fail_idx_q;
        got_addr_d  = got_addr_q;
        got_data_d  = got_data_q;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            IDLE: begin
                // a load accepted this same cycle counts toward a non-empty table
                if (start_i && (count_nx != '0)) begin
                    state_d     = RUN;
                    idx_d       = '0;
                    match_cnt_d = '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
                    timer_d     = '0;
`endif
                end
            end
            RUN: begin
                // a store always wins over the timeout on the boundary cycle
                if (MemWrite_i) begin
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (store_ok) begin
                        match_cnt_d = match_cnt_q + CNT_W'(1);
                        if (last_entry) state_d = PASS;
                        else            idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        state_d    = FAIL;
                        fail_idx_d = idx_q;
                        got_addr_d = ALUResult_i;
                        got_data_d = WriteData_i;
                    end
                end
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
                else if (timer_q == TMR_LAST) begin
                    state_d     = FAIL;
                    timed_out_d = 1'b1;
                    fail_idx_d  = idx_q;
                    got_addr_d  = '0;
                    got_data_d  = '0;
                end else begin
                    // the fail branch above stops it at TMR_LAST, so it never wraps
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            PASS, FAIL: begin
                // rerun on the same table; loading stays closed until reset
                if (start_i) begin
                    state_d     = RUN;
                    idx_d       = '0;
                    match_cnt_d = '0;
                    fail_idx_d  = '0;
                    got_addr_d  = '0;
                    got_data_d  = '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
                    timer_d     = '0;
                    timed_out_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == PASS) || (state_d == FAIL);
        pass_d = (state_d == PASS);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            match_cnt_q <= '0;
            fail_idx_q  <= '0;
            got_addr_q  <= '0;
            got_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            match_cnt_q <= match_cnt_d;
            fail_idx_q  <= fail_idx_d;
            got_addr_q  <= got_addr_d;
            got_data_q  <= got_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    // Idle timer and timeout flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
        end
    end
    assign timed_out_o = timed_out_q;
`else
    assign timed_out_o = 1'b0;
`endif

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_idx_o  = fail_idx_q;
    assign got_addr_o  = got_addr_q;
    assign got_data_o  = got_data_q;
    assign match_cnt_o = match_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed vectors with hand-computed expectations for
// mem_write_checker (DEPTH=4, TIMEOUT=16).
module tb_mem_write_checker;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              MemWrite;
    logic [ADDR_W-1:0] ALUResult;
    logic [DATA_W-1:0] WriteData;
    logic              busy, done, pass, timed_out;
    logic [1:0]        fail_idx;
    logic [ADDR_W-1:0] got_addr;
    logic [DATA_W-1:0] got_data;
    logic [2:0]        match_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_write_checker #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_addr_i  (load_addr),
        .load_data_i  (load_data),
        .start_i      (start),
        .MemWrite_i   (MemWrite),
        .ALUResult_i  (ALUResult),
        .WriteData_i  (WriteData),
        .busy_o       (busy),
        .done_o       (done),
        .pass_o       (pass),
        .timed_out_o  (timed_out),
        .fail_idx_o   (fail_idx),
        .got_addr_o   (got_addr),
        .got_data_o   (got_data),
        .match_cnt_o  (match_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // advance one rising edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input int a, input int d);
        load_valid = 1'b1;
        load_addr  = ADDR_W'(a);
        load_data  = DATA_W'(d);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic store(input int a, input int d);
        MemWrite  = 1'b1;
        ALUResult = ADDR_W'(a);
        WriteData = DATA_W'(d);
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"},      64'(busy),      64'd0);
        chk({pfx, "_done"},      64'(done),      64'd0);
        chk({pfx, "_pass"},      64'(pass),      64'd0);
        chk({pfx, "_timed_out"}, 64'(timed_out), 64'd0);
        chk({pfx, "_fail_idx"},  64'(fail_idx),  64'd0);
        chk({pfx, "_got_addr"},  64'(got_addr),  64'd0);
        chk({pfx, "_got_data"},  64'(got_data),  64'd0);
        chk({pfx, "_match_cnt"}, 64'(match_cnt), 64'd0);
        chk({pfx, "_load_ready"}, 64'(load_ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
        #1;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_outputs("rst");

        // full match
        load(100, 7);
        load(104, 9);
        go();
        chk("run_busy", 64'(busy), 64'd1);
        store(100, 7);
        chk("m1_cnt", 64'(match_cnt), 64'd1);
        chk("m1_done", 64'(done), 64'd0);
        store(104, 9);
        chk("m2_done", 64'(done), 64'd1);
        chk("m2_pass", 64'(pass), 64'd1);
        chk("m2_cnt", 64'(match_cnt), 64'd2);
        chk("m2_busy", 64'(busy), 64'd0);
        chk("pass_ldrdy", 64'(load_ready), 64'd0);
        store(55, 55);
        chk("pass_sticky", 64'(pass), 64'd1);

        // data mismatch, restarted from PASS on the same table
        go();
        chk("rs_busy", 64'(busy), 64'd1);
        chk("rs_cnt0", 64'(match_cnt), 64'd0);
        store(100, 7);
        store(104, 8);
        chk("mm_done", 64'(done), 64'd1);
        chk("mm_pass", 64'(pass), 64'd0);
        chk("mm_idx", 64'(fail_idx), 64'd1);
        chk("mm_addr", 64'(got_addr), 64'd104);
        chk("mm_data", 64'(got_data), 64'd8);
        chk("mm_cnt", 64'(match_cnt), 64'd1);
        chk("mm_to", 64'(timed_out), 64'd0);

        // restart from FAIL clears captures, then passes
        go();
        chk("rf_busy", 64'(busy), 64'd1);
        chk("rf_cnt", 64'(match_cnt), 64'd0);
        chk("rf_addr", 64'(got_addr), 64'd0);
        chk("rf_idx", 64'(fail_idx), 64'd0);
        store(100, 7);
        store(104, 9);
        chk("rf_pass", 64'(pass), 64'd1);
        chk("rf_cnt2", 64'(match_cnt), 64'd2);

        // store on the timeout boundary cycle wins
        do_reset();
        load(200, 5);
        go();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("bd_busy", 64'(busy), 64'd1);
        store(200, 5);
        chk("bd_pass", 64'(pass), 64'd1);
        chk("bd_to", 64'(timed_out), 64'd0);

        // timeout: verdict exactly TIMEOUT cycles after the start edge
        go();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_pre_busy", 64'(busy), 64'd1);
        chk("to_pre_done", 64'(done), 64'd0);
        tick();
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
        chk("to_done", 64'(done), 64'd1);
        chk("to_pass", 64'(pass), 64'd0);
        chk("to_flag", 64'(timed_out), 64'd1);
        chk("to_idx", 64'(fail_idx), 64'd0);
        chk("to_addr", 64'(got_addr), 64'd0);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("noto_busy", 64'(busy), 64'd1);
        chk("noto_flag", 64'(timed_out), 64'd0);
`endif

        // full table: fifth load refused
        do_reset();
        load(10, 1);
        load(20, 2);
        load(30, 3);
        chk("ft_rdy3", 64'(load_ready), 64'd1);
        load(40, 4);
        chk("ft_rdy4", 64'(load_ready), 64'd0);
        load(50, 5);
        go();
        store(10, 1);
        store(20, 2);
        store(30, 3);
        chk("ft_busy3", 64'(busy), 64'd1);
        store(40, 4);
        chk("ft_pass", 64'(pass), 64'd1);
        chk("ft_cnt", 64'(match_cnt), 64'd4);

        // empty start ignored, store in IDLE ignored
        do_reset();
        go();
        chk("es_busy", 64'(busy), 64'd0);
        chk("es_done", 64'(done), 64'd0);
        store(1, 1);
        chk("iw_busy", 64'(busy), 64'd0);
        chk("iw_done", 64'(done), 64'd0);
        chk("iw_rdy", 64'(load_ready), 64'd1);

        // load and start in the same cycle
        load_valid = 1'b1; load_addr = 32'd300; load_data = 32'd3; start = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        chk("ls_busy", 64'(busy), 64'd1);
        store(300, 3);
        chk("ls_pass", 64'(pass), 64'd1);
        chk("ls_cnt", 64'(match_cnt), 64'd1);

        // reset mid-RUN empties the table
        do_reset();
        load(100, 7);
        load(104, 9);
        go();
        store(100, 7);
        chk("mr_cnt", 64'(match_cnt), 64'd1);
        do_reset();
        chk_reset_outputs("mr");
        go();
        chk("mr_empty", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable self-checking monitor that sits beside the processor `top` and watches its data-memory write port (`MemWrite`, `ALUResult`, `WriteData`). It holds a loaded table of expected (address, data) stores and delivers a registered pass/fail verdict. It replaces ad-hoc single-address checks with an ordered, depth-parametrised sequence, first-mismatch capture and an inactivity timeout. It is used both in simulation and on FPGA, driving LEDs.

## Interface
- `DATA_W`, default 32: width of `WriteData` and the expected data.
- `ADDR_W`, default 32: width of `ALUResult` and the expected address.
- `DEPTH`, default 8: number of expected-store entries; must be at least 1.
- `TIMEOUT`, default 1024: idle cycles allowed between matched stores; must be at least 2.
- `clk` in 1: single clock. Everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-high.
- `load_valid` in 1: an expected entry is offered.
- `load_ready` out 1: the entry is accepted on any cycle where `load_valid && load_ready`.
- `load_addr` in ADDR_W: expected store address.
- `load_data` in DATA_W: expected store data.
- `start` in 1: arms the check.
- `MemWrite` in 1: the processor's store strobe.
- `ALUResult` in ADDR_W: store address.
- `WriteData` in DATA_W: store data.
- `busy` out 1: high while in RUN.
- `done` out 1: high in PASS or FAIL.
- `pass` out 1: high in PASS only.
- `timed_out` out 1: a FAIL caused by the timeout.
- `fail_idx` out clog2(DEPTH): index of the entry that failed.
- `got_addr` out ADDR_W: address of the offending store.
- `got_data` out DATA_W: data of the offending store.
- `match_cnt` out clog2(DEPTH+1): number of stores matched so far.

## Operation
- **States.** The state machine has four states: IDLE, RUN, PASS, FAIL.
- **Reset.** Puts the block in IDLE and clears the table count, `match_cnt`, `fail_idx`, `got_addr`, `got_data` and the timer. After reset every output is 0 except `load_ready`, which is 1.
- **IDLE, loading.**
  - `load_ready` = (state==IDLE) && (count<DEPTH).
  - An accepted entry is written at index `count`, and `count` increments.
- **IDLE, starting.**
  - `start` with `count_next>0` moves to RUN with idx=0 and the timer at 0.
  - `count_next` is the count after any load accepted in the same cycle, so a same-cycle load is included.
  - `start` with an empty table is ignored.
- **RUN, store matches.** On a `MemWrite` cycle where `ALUResult==addr[idx]` and `WriteData==data[idx]`:
  - idx and `match_cnt` increment and the timer clears.
  - If idx==count-1, the block goes to PASS.
- **RUN, store mismatches.** On a `MemWrite` cycle with any mismatch:
  - The block goes to FAIL.
  - `fail_idx`=idx, and `got_addr`/`got_data` take the offending values.
- **RUN, timeout.** On a cycle without `MemWrite` the timer increments. When the timer reaches TIMEOUT-1:
  - The block goes to FAIL with `timed_out`=1 and `fail_idx`=idx.
  - `got_addr`/`got_data` are set to 0.
- **PASS and FAIL.** Both are sticky. `start` re-enters RUN on the same table, clearing `match_cnt`, `timed_out` and the capture registers. No loading is allowed until reset.
- **Stores outside RUN.** `MemWrite` in IDLE, PASS or FAIL is ignored.
- **`start` during RUN.** Ignored.
- **Reset mid-RUN.** Returns to IDLE and empties the table.

## Timing
- A verdict is registered on the same edge that samples the deciding `MemWrite`. `done`, `pass` and `fail_idx` are valid one cycle after the store cycle.
- Back-to-back stores, one per cycle, are all checked. There are no bubbles.
- All outputs are driven directly from registers. The only exception is `load_ready`, which decodes state and count combinationally.
- The timer is clog2(TIMEOUT) bits wide and saturates; it never wraps.
- **Timeout boundary.** If `MemWrite` is asserted on the cycle the timer reaches TIMEOUT-1, the store takes priority and is checked normally; no timeout is raised.

## Configuration
- Macro: `MEM_WRITE_CHECKER_TIMEOUT_EN`.
- **Defined:** the timer and the `timed_out` path are built as described above.
- **Undefined:**
  - The timer logic is removed and `timed_out` is tied to 0.
  - RUN waits indefinitely for stores.
  - The `TIMEOUT` parameter is accepted but unused.

## Structure
- **Package `mem_write_checker_pkg`:**
  - State enum: IDLE=2'd0, RUN=2'd1, PASS=2'd2, FAIL=2'd3.
  - The localparam widths derived with clog2.
- **Sub-module `exp_table`:**
  - DEPTH×(ADDR_W+DATA_W) register file.
  - One synchronous write port and one combinational read port indexed by idx.
  - No reset on its contents; `count` gates validity.
- **Top level:** FSM, timer, counters and capture registers.

## Test plan
- **Full match.** Load (100,7), (104,9), then start; stores (100,7), (104,9) → `done`=1, `pass`=1, `match_cnt`=2 one cycle after the second store.
- **Data mismatch.** Same table; stores (100,7), (104,8) → FAIL, `fail_idx`=1, `got_addr`=104, `got_data`=8, `pass`=0.
- **Timeout.** TIMEOUT=16, one entry, start, no stores → FAIL with `timed_out`=1, `fail_idx`=0 exactly 16 cycles after the start edge. With the macro undefined, the block is still `busy` after 100 cycles.
- **Full table and edge cases.** DEPTH=4, five loads offered → the fifth is not accepted because `load_ready`=0. `start` with an empty table → stays IDLE. A load and `start` in the same cycle → the entry is counted.
- **Restart.** From FAIL, `start` plus the correct stores → PASS with `match_cnt` restarted at 0. `MemWrite` in IDLE → no state change.
- **Reset mid-RUN.** `reset` after one matched store → all outputs return to their reset values, and `load_ready`=1 on the next cycle.
